// File: rtl/timer_pkg.sv
// State encoding shared by the down-counting timer.
package timer_pkg;
  typedef enum logic {IDLE, RUN} timer_state_t;
endpackage

// File: rtl/down_timer.sv
// Loadable one-shot/periodic down-timer. q loads on the start edge, done pulses
// the cycle after expiry, and pausing (en=0 or dec=0) simply holds the count.
module down_timer
  import timer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         mode_reload,
  input  logic         en,
  input  logic         dec,
  input  logic         abort,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  timer_state_t state, state_nxt;
  logic [N-1:0] reload_reg, reload_nxt, q_nxt;
  logic         mode_reg, mode_nxt, done_nxt;

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload_reg;
    mode_nxt   = mode_reg;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          q_nxt      = load_val;
          reload_nxt = load_val;
          mode_nxt   = mode_reload;
          if (load_val != '0) state_nxt = RUN;
          else                done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          q_nxt     = '0;
          state_nxt = IDLE;
        end else if (start) begin
          q_nxt      = load_val;
          reload_nxt = load_val;
          mode_nxt   = mode_reload;
          // A zero restart expires immediately and never enters a reload loop.
          if (load_val == '0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (en && dec) begin
          if (q > ONE) begin
            q_nxt = q - ONE;
          end else if (q == ONE) begin
            done_nxt = 1'b1;
            if (mode_reg) begin
              q_nxt = reload_reg;
            end else begin
              q_nxt     = '0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      reload_reg <= reload_nxt;
      mode_reg   <= mode_nxt;
      busy       <= (state_nxt == RUN);
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: each step queues the expected post-edge outputs,
// and an independent monitor pops and compares them on the falling edge.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       reset, start, mode_reload, en, dec, abort;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       busy, done;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  down_timer #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .mode_reload(mode_reload), .en(en), .dec(dec), .abort(abort),
    .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done) begin
        fails++;
        $display("FAIL %s: got q=%0d busy=%0b done=%0b, expected q=%0d busy=%0b done=%0b",
                 e.name, q, busy, done, e.q, e.busy, e.done);
      end
    end
  end

  // Drive one cycle of inputs, queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic s, input logic [7:0] lv, input logic m,
                      input logic e_in, input logic d_in, input logic a,
                      input logic [7:0] eq, input logic eb, input logic ed, input string nm);
    exp_t x;
    reset = r; start = s; load_val = lv; mode_reload = m;
    en = e_in; dec = d_in; abort = a;
    x.q = eq; x.busy = eb; x.done = ed; x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with start asserted is ignored
    for (int i = 0; i < 2; i++) step(1, 1, 8'd5, 0, 1, 1, 0, 8'd0, 0, 0, "reset");
    step(0, 0, 8'd5, 0, 1, 1, 0, 8'd0, 0, 0, "after_reset");

    // one-shot 3
    step(0, 1, 8'd3, 0, 1, 1, 0, 8'd3, 1, 0, "oneshot_load");
    step(0, 0, 8'd3, 0, 1, 1, 0, 8'd2, 1, 0, "oneshot_2");
    step(0, 0, 8'd3, 0, 1, 1, 0, 8'd1, 1, 0, "oneshot_1");
    step(0, 0, 8'd3, 0, 1, 1, 0, 8'd0, 0, 1, "oneshot_expire");
    step(0, 0, 8'd3, 0, 1, 1, 0, 8'd0, 0, 0, "oneshot_idle");

    // periodic 2
    step(0, 1, 8'd2, 1, 1, 1, 0, 8'd2, 1, 0, "periodic_load");
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 8'd2, 1, 1, 1, 0, 8'd1, 1, 0, "periodic_1");
      step(0, 0, 8'd2, 1, 1, 1, 0, 8'd2, 1, 1, "periodic_reload");
    end
    step(0, 0, 8'd2, 1, 1, 1, 1, 8'd0, 0, 0, "periodic_abort");

    // pause
    step(0, 1, 8'd4, 0, 1, 1, 0, 8'd4, 1, 0, "pause_load");
    step(0, 0, 8'd4, 0, 1, 1, 0, 8'd3, 1, 0, "pause_3");
    step(0, 0, 8'd4, 0, 1, 1, 0, 8'd2, 1, 0, "pause_2");
    for (int i = 0; i < 5; i++) step(0, 0, 8'd4, 0, 0, 1, 0, 8'd2, 1, 0, "pause_en0");
    for (int i = 0; i < 3; i++) step(0, 0, 8'd4, 0, 1, 0, 0, 8'd2, 1, 0, "pause_dec0");
    step(0, 0, 8'd4, 0, 1, 1, 0, 8'd1, 1, 0, "pause_resume_1");
    step(0, 0, 8'd4, 0, 0, 1, 0, 8'd1, 1, 0, "pause_at_1");
    step(0, 0, 8'd4, 0, 1, 1, 0, 8'd0, 0, 1, "pause_expire");

    // abort / restart
    step(0, 1, 8'd10, 0, 1, 1, 0, 8'd10, 1, 0, "restart_load10");
    step(0, 0, 8'd10, 0, 1, 1, 0, 8'd9, 1, 0, "restart_9");
    step(0, 0, 8'd10, 0, 1, 1, 0, 8'd8, 1, 0, "restart_8");
    step(0, 0, 8'd10, 0, 1, 1, 0, 8'd7, 1, 0, "restart_7");
    step(0, 1, 8'd3, 0, 1, 1, 0, 8'd3, 1, 0, "restart_load3");
    step(0, 1, 8'd6, 0, 1, 1, 1, 8'd0, 0, 0, "abort_over_start");
    step(0, 0, 8'd6, 0, 1, 1, 1, 8'd0, 0, 0, "abort_in_idle");

    // zero load in IDLE, periodic requested
    step(0, 1, 8'd0, 1, 1, 1, 0, 8'd0, 0, 1, "zero_load");
    step(0, 0, 8'd0, 1, 1, 1, 0, 8'd0, 0, 0, "zero_no_repeat");
    step(0, 0, 8'd0, 1, 1, 1, 0, 8'd0, 0, 0, "zero_no_repeat2");

    // zero restart while running
    step(0, 1, 8'd2, 0, 1, 1, 0, 8'd2, 1, 0, "zrestart_load");
    step(0, 1, 8'd0, 0, 1, 1, 0, 8'd0, 0, 1, "zrestart_zero");
    step(0, 0, 8'd0, 0, 1, 1, 0, 8'd0, 0, 0, "zrestart_idle");

    // mode/load changes during RUN are ignored until next start
    step(0, 1, 8'd1, 1, 1, 1, 0, 8'd1, 1, 0, "captured_load1");
    step(0, 0, 8'd9, 0, 1, 1, 0, 8'd1, 1, 1, "captured_reload");
    step(0, 0, 8'd9, 0, 1, 1, 1, 8'd0, 0, 0, "captured_abort");

    // reset on the expiry edge
    step(0, 1, 8'd5, 0, 1, 1, 0, 8'd5, 1, 0, "rst_load5");
    step(0, 0, 8'd5, 0, 1, 1, 0, 8'd4, 1, 0, "rst_4");
    step(0, 0, 8'd5, 0, 1, 1, 0, 8'd3, 1, 0, "rst_3");
    step(0, 0, 8'd5, 0, 1, 1, 0, 8'd2, 1, 0, "rst_2");
    step(0, 0, 8'd5, 0, 1, 1, 0, 8'd1, 1, 0, "rst_1");
    step(1, 0, 8'd5, 0, 1, 1, 0, 8'd0, 0, 0, "rst_on_expiry");
    step(0, 0, 8'd5, 0, 1, 1, 0, 8'd0, 0, 0, "rst_after");

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Synchronous, loadable down-counter/timer: the decrementing counterpart to the team's up-counter.
- A start pulse loads a count value, which is then decremented by dec on each enabled clock edge.
- Reaching zero produces a one-cycle done pulse. The timer then stops (one-shot) or reloads the captured value (periodic).
- Used as a tick/timeout generator beside the counter in datapath control.

Parameters:
N, 8, width in bits of the count value q and of load_val

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  load load_val and begin counting (single-cycle strobe; level also accepted)
load_val  input  N  count value captured on start
mode_reload  input  1  1 = periodic reload, 0 = one-shot; captured on start
en  input  1  counting enable; 0 = pause
dec  input  1  decrement amount (0 or 1), applied only when en=1
abort  input  1  cancel a running count without done
q  output  N  current count value
busy  output  1  1 while in RUN
done  output  1  registered one-cycle pulse on expiry

Behaviour:
- Interface: one clock clk. reset is synchronous and active-high: it is sampled only on the rising edge of clk.
- Reset: q=0, busy=0, done=0, reload_reg=0, mode_reg=0, state=IDLE.
- Priority per edge: reset > abort > start > decrement/hold.
- done defaults to 0 every cycle. It is 1 only in the cycle after an expiry edge.
- States: IDLE, RUN.
- IDLE, start=1:
  - q<=load_val, reload_reg<=load_val, mode_reg<=mode_reload.
  - If load_val!=0: go to RUN.
  - If load_val==0: done<=1, stay in IDLE. No reload loop, even when mode_reload=1.
- IDLE, otherwise: q holds, busy=0. abort in IDLE has no effect.
- RUN, abort=1: q<=0, go to IDLE, done stays 0.
- RUN, start=1 (restart): q<=load_val, reload_reg/mode_reg re-captured, stay in RUN, no done. If load_val==0, same as the IDLE zero case: done<=1, go to IDLE.
- RUN, en=1 and dec=1:
  - If q>1: q<=q-1.
  - If q==1 (expiry): done<=1. When mode_reg=1, q<=reload_reg and stay in RUN. When mode_reg=0, q<=0 and go to IDLE.
- RUN, en=0 or dec=0: q holds. Pausing never causes or loses an expiry.
- Periodic period = reload_reg enabled decrements per done pulse.
- busy is registered: busy=1 exactly when state==RUN.
- Latency: q updates on the edge that samples start; done asserts the edge after the final decrement is sampled (same edge q becomes 0/reload).
- No wrap-around: q never decrements below 0. Expiry is detected at q==1, never by underflow.
- Load/dec arithmetic is N bits, unsigned.
- mode_reload and load_val changes while RUN are ignored until the next start.
- Reset mid-RUN: next cycle is the full reset state, with no done pulse.

Decomposition:
- timer_pkg holds typedef enum logic {IDLE, RUN} timer_state_t. No other constants.
- Single module, no sub-module. The next-state/q logic is one always_ff with an always_comb next-state block.

Test Plan:
- Reset: hold reset 2 cycles with start=1, load_val=8'd5 -> q=0, busy=0, done=0 after release; start is ignored during reset.
- One-shot: load_val=3, mode_reload=0, start 1 cycle, en=dec=1 -> q=3,2,1,0 on successive edges; done=1 only in the cycle q first reads 0; busy falls to 0 that same cycle.
- Periodic: load_val=2, mode_reload=1, en=dec=1 -> q=2,1,2,1,2; done pulses in every cycle q returns to 2 after a 1, i.e. every 2 cycles; busy stays 1.
- Pause: load_val=4, run to q=2, hold en=0 for 5 cycles, then dec=0 for 3 cycles -> q stays 2, no done. Resume -> q=1, then 0 with done.
- Abort/restart: load_val=10 and run to q=7. Assert start with load_val=3 -> q=3, no done. Then assert abort and start together -> q=0, busy=0, no done.
- Zero load and reset mid-run: start with load_val=0, mode_reload=1 -> done single pulse, busy=0, no further pulses. Then load_val=5, run to q=1, assert reset on the expiry edge -> q=0, done=0.
